// File: rtl/spi_burst_engine.sv
// ============================================================================
// Module   : spi_burst_engine
// Purpose  : Multi-byte SPI transfer engine between the CPU bus and spi_ctrl.
//            TX bytes are queued in a FIFO and handed to spi_ctrl one byte at
//            a time; received bytes are collected in an RX FIFO. A fill
//            counter generates 0xFF bytes (SD-card block reads).
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            i_bus_addr[1:0]   - 0=CTRL 1=TXDATA 2=RXDATA 3=STATUS/FILL
//            i_bus_wdata[15:0] - bus write data
//            i_bus_wr_n        - write strobe, active-low, one cycle
//            i_bus_rd_n        - read strobe, active-low, one cycle
//            o_bus_rdata[15:0] - read data, combinational from i_bus_addr
//            o_spi_datain      - to spi_ctrl: [15:8] TX byte, [7:0] control
//            o_spi_wrh_n       - to spi_ctrl: one-cycle start strobe, active-low
//            i_spi_dataout     - from spi_ctrl: [15:8] RX byte, [7] busy
//            o_irq             - transfer-done interrupt
// Config   : SPI_BURST_IRQ_EN - when defined, CTRL[8] enables a registered
//            level interrupt; when undefined o_irq is tied low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_burst_engine #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  i_bus_addr,
  input  logic [15:0] i_bus_wdata,
  input  logic        i_bus_wr_n,
  input  logic        i_bus_rd_n,
  output logic [15:0] o_bus_rdata,
  output logic [15:0] o_spi_datain,
  output logic        o_spi_wrh_n,
  input  logic [15:0] i_spi_dataout,
  output logic        o_irq
);

  localparam logic [DEPTH_LOG2:0] c_PTR_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0] c_FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WSTART = 2'd2,
    S_WDONE  = 2'd3
  } state_t;

  state_t              r_state, w_state_next;
  logic [6:0]          r_ctrl, r_ctrl_act;
  logic [15:0]         r_fill_cnt;
  logic [7:0]          r_tx_byte;
  logic                r_tx_ovf;
  logic [7:0]          r_tx_mem [0:(1<<DEPTH_LOG2)-1];
  logic [7:0]          r_rx_mem [0:(1<<DEPTH_LOG2)-1];
  logic [DEPTH_LOG2:0] r_tx_wptr, r_tx_rptr, r_rx_wptr, r_rx_rptr;
  logic [DEPTH_LOG2:0] w_tx_level, w_rx_level;
  logic                w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic                w_wr_ctrl, w_wr_tx, w_wr_fill, w_rd_rx, w_rd_stat, w_flush;
  logic                w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_fill_dec;
  logic                w_can_start, w_start, w_done, w_busy, w_irq_en;
  logic [7:0]          w_tx_head, w_rx_head;
  logic [15:0]         w_status;
  logic                w_unused;

  assign w_unused = ^{i_spi_dataout[6:0], i_bus_wdata[15:8]};

  // ---------------- bus decode ----------------
  assign w_wr_ctrl = !i_bus_wr_n && (i_bus_addr == 2'd0);
  assign w_wr_tx   = !i_bus_wr_n && (i_bus_addr == 2'd1);
  assign w_wr_fill = !i_bus_wr_n && (i_bus_addr == 2'd3);
  assign w_rd_rx   = !i_bus_rd_n && (i_bus_addr == 2'd2);
  assign w_rd_stat = !i_bus_rd_n && (i_bus_addr == 2'd3);
  assign w_flush   = w_wr_ctrl && i_bus_wdata[7];

  // ---------------- FIFO status ----------------
  // Pointers carry one extra bit so full and empty are distinguishable.
  assign w_tx_level = r_tx_wptr - r_tx_rptr;
  assign w_rx_level = r_rx_wptr - r_rx_rptr;
  assign w_tx_empty = (w_tx_level == '0);
  assign w_rx_empty = (w_rx_level == '0);
  assign w_tx_full  = (w_tx_level == c_FULL_LVL);
  assign w_rx_full  = (w_rx_level == c_FULL_LVL);
  assign w_tx_head  = r_tx_mem[r_tx_rptr[DEPTH_LOG2-1:0]];
  assign w_rx_head  = r_rx_mem[r_rx_rptr[DEPTH_LOG2-1:0]];

  // Pushes test the full flag as it stands, so a push into a full FIFO is
  // dropped even if a pop happens in the same cycle.
  assign w_tx_push  = w_wr_tx && !w_tx_full && !w_flush;
  assign w_rx_pop   = w_rd_rx && !w_rx_empty;
  assign w_can_start = r_ctrl[5] && (!w_tx_empty || (r_fill_cnt != 16'd0))
                       && (!w_rx_full || r_ctrl[6]);
  assign w_tx_pop   = w_start && !w_tx_empty;
  assign w_fill_dec = w_start && w_tx_empty;
  // Discard decision uses the snapshot taken when the byte started.
  assign w_rx_push  = w_done && !r_ctrl_act[6] && !w_rx_full && !w_flush;
  assign w_busy     = (r_state != S_IDLE) || !w_tx_empty || (r_fill_cnt != 16'd0);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_done       = 1'b0;
    o_spi_wrh_n  = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_can_start) begin
          w_start      = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        o_spi_wrh_n  = 1'b0;
        w_state_next = S_WSTART;
      end
      S_WSTART: begin
        // spi_ctrl raises busy one cycle after it sees the strobe.
        if (i_spi_dataout[7]) w_state_next = S_WDONE;
      end
      S_WDONE: begin
        if (!i_spi_dataout[7]) begin
          w_done       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_fill_cnt <= 16'd0;
      r_ctrl     <= 7'd0;
      r_ctrl_act <= 7'd0;
      r_tx_byte  <= 8'd0;
      r_tx_ovf   <= 1'b0;
    end else begin
      if (w_flush) begin
        // Flush empties both FIFOs; it overrides any push in this cycle.
        r_tx_rptr <= r_tx_wptr;
        r_rx_rptr <= r_rx_wptr;
      end else begin
        if (w_tx_push) r_tx_wptr <= r_tx_wptr + c_PTR_ONE;
        if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + c_PTR_ONE;
        if (w_rx_push) r_rx_wptr <= r_rx_wptr + c_PTR_ONE;
        if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + c_PTR_ONE;
      end

      if (w_flush)         r_fill_cnt <= 16'd0;
      else if (w_wr_fill)  r_fill_cnt <= i_bus_wdata;
      else if (w_fill_dec) r_fill_cnt <= r_fill_cnt - 16'd1;

      if (w_wr_ctrl) r_ctrl <= i_bus_wdata[6:0];
      // Control seen by spi_ctrl only tracks CTRL between bytes.
      if (r_state == S_IDLE) r_ctrl_act <= r_ctrl;

      if (w_tx_pop)        r_tx_byte <= w_tx_head;
      else if (w_fill_dec) r_tx_byte <= 8'hFF;

      if (w_wr_tx && w_tx_full) r_tx_ovf <= 1'b1;
      else if (w_rd_stat)       r_tx_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr[DEPTH_LOG2-1:0]] <= i_bus_wdata[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wptr[DEPTH_LOG2-1:0]] <= i_spi_dataout[15:8];
  end

  // Bit 6 (rx_discard) is an engine-only setting and is never sent.
  assign o_spi_datain = {r_tx_byte, 2'b00, r_ctrl_act[5:0]};

  // ---------------- interrupt ----------------
`ifdef SPI_BURST_IRQ_EN
  logic r_irq_en;
  logic r_irq;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_irq_en <= i_bus_wdata[8];
      r_irq <= r_irq_en && (r_state == S_IDLE) && w_tx_empty && (r_fill_cnt == 16'd0);
    end
  end
  assign w_irq_en = r_irq_en;
  assign o_irq    = r_irq;
`else
  assign w_irq_en = 1'b0;
  assign o_irq    = 1'b0;
`endif

  // ---------------- read mux ----------------
  always_comb begin
    w_status                 = 16'd0;
    w_status[15]             = w_busy;
    w_status[14]             = w_tx_full;
    w_status[13]             = w_tx_empty;
    w_status[12]             = w_rx_full;
    w_status[11]             = w_rx_empty;
    w_status[10]             = r_tx_ovf;
    w_status[DEPTH_LOG2:0]   = w_rx_level;
    o_bus_rdata              = 16'd0;
    case (i_bus_addr)
      2'd0:    o_bus_rdata = {7'd0, w_irq_en, 1'b0, r_ctrl};
      2'd2:    o_bus_rdata = w_rx_empty ? 16'd0 : {8'h00, w_rx_head};
      2'd3:    o_bus_rdata = w_status;
      default: o_bus_rdata = 16'd0;
    endcase
  end

endmodule

`default_nettype wire
